// File: rtl/mips_pkg.sv
// Shared MIPS definitions: funct codes for the HI/LO ops and the
// multiply/divide unit's state encoding and per-op flag bundle.
package mips_pkg;

  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1a;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mdu_state_t;

  // Everything the FIX step needs to know about the op, captured at accept.
  typedef struct packed {
    logic is_div;    // divide (1) or multiply (0)
    logic neg_res;   // negate product / quotient
    logic neg_rem;   // negate remainder
    logic div_zero;  // divisor was zero
    logic ovf;       // most-negative / -1 signed divide
  } mdu_flags_t;

  // True for the ops that run through the iterative datapath.
  function automatic logic is_calc_op(input logic [5:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
           (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// One-bit-per-cycle datapath: radix-2 shift-add multiply or restoring
// divide on unsigned WIDTH-bit magnitudes, result held in a 2*WIDTH
// accumulator. Multiply leaves the product; divide leaves
// {remainder, quotient}.
module mdu_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,      // latch operands, clear accumulator top
  input  logic               step,      // perform one iteration
  input  logic               mode_div,  // sampled with load: 1 = divide
  input  logic [WIDTH-1:0]   op_a,      // multiplicand / dividend
  input  logic [WIDTH-1:0]   op_b,      // multiplier / divisor
  output logic [2*WIDTH-1:0] acc
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand or divisor
  logic               mode_q, mode_d;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     trial;

  // Next-state for one iteration, or operand load.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and a latch is inferred.
    acc_d  = acc_q;
    opnd_d = opnd_q;
    mode_d = mode_q;
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
              {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
    trial   = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};

    if (load) begin
      mode_d = mode_div;
      opnd_d = mode_div ? op_b : op_a;
      acc_d  = {{WIDTH{1'b0}}, (mode_div ? op_a : op_b)};
    end else if (step) begin
      if (!mode_q) begin
        // Add multiplicand when the current multiplier bit is set, then shift right.
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
      end else if (!trial[WIDTH]) begin
        // Shifted remainder >= divisor: keep the difference, quotient bit 1.
        acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        // Restore: keep the shifted remainder, quotient bit 0.
        acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: datapath flops are reset too so nothing undefined reaches hi/lo after reset.
    if (reset) begin
      acc_q  <= '0;
      opnd_q <= '0;
      mode_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so all flops update together from pre-edge values.
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      mode_q <= mode_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. FSM IDLE -> CALC
// (WIDTH iterations) -> FIX (sign correction, special cases, HI/LO write).
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_content,
  input  logic [WIDTH-1:0] rt_content,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  mdu_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  mdu_flags_t         flags_q, flags_d;
  logic [WIDTH-1:0]   rs_raw_q, rs_raw_d;   // raw dividend for divide-by-zero

  logic               accept;
  logic               calc_go;
  logic               in_div;
  logic               in_signed;
  logic               rs_neg;
  logic               rt_neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  // Decode the incoming request and convert signed operands to magnitudes.
  always_comb begin
    accept    = (state_q == IDLE) && start && !cancel;
    calc_go   = accept && is_calc_op(funct);
    in_div    = (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
    in_signed = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
    rs_neg    = in_signed && rs_content[WIDTH-1];
    rt_neg    = in_signed && rt_content[WIDTH-1];
    mag_a     = rs_neg ? (~rs_content + 1'b1) : rs_content;
    mag_b     = rt_neg ? (~rt_content + 1'b1) : rt_content;
  end

  mdu_iter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (calc_go),
    .step     (state_q == CALC),
    .mode_div (in_div),
    .op_a     (mag_a),
    .op_b     (mag_b),
    .acc      (acc)
  );

  // Final HI/LO values from the accumulator, sign flags and special cases.
  always_comb begin
    prod   = flags_q.neg_res ? (~acc + 1'b1) : acc;
    quot   = acc[WIDTH-1:0];
    rem    = acc[2*WIDTH-1:WIDTH];
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (flags_q.is_div) begin
      if (flags_q.div_zero) begin
        fix_lo = {WIDTH{1'b1}};
        fix_hi = rs_raw_q;
      end else if (flags_q.ovf) begin
        fix_lo = MOST_NEG;
        fix_hi = '0;
      end else begin
        fix_lo = flags_q.neg_res ? (~quot + 1'b1) : quot;
        fix_hi = flags_q.neg_rem ? (~rem + 1'b1) : rem;
      end
    end
  end

  // FSM, iteration counter and HI/LO write control.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    flags_d  = flags_q;
    rs_raw_d = rs_raw_q;

    unique case (state_q)
      IDLE: begin
        if (calc_go) begin
          state_d          = CALC;
          cnt_d            = '0;
          rs_raw_d         = rs_content;
          flags_d.is_div   = in_div;
          flags_d.neg_res  = rs_neg ^ rt_neg;
          flags_d.neg_rem  = rs_neg;
          flags_d.div_zero = (rt_content == '0);
          flags_d.ovf      = in_signed && in_div &&
                             (rs_content == MOST_NEG) &&
                             (rt_content == {WIDTH{1'b1}});
        end else if (accept && (funct == FUNCT_MTHI)) begin
          hi_d = rs_content;
        end else if (accept && (funct == FUNCT_MTLO)) begin
          lo_d = rs_content;
        end
      end
      CALC: begin
        if (cancel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) begin
            state_d = FIX;
          end
        end
      end
      FIX: begin
        state_d = IDLE;
        cnt_d   = '0;
        if (!cancel) begin
          hi_d   = fix_hi;
          lo_d   = fix_lo;
          done_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Control and architectural registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      flags_q  <= '0;
      rs_raw_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      flags_q  <= flags_d;
      rs_raw_q <= rs_raw_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (WIDTH = 32).
module tb_mult_div_unit;
  import mips_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] rs_content;
  logic [31:0] rt_content;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .funct      (funct),
    .rs_content (rs_content),
    .rt_content (rt_content),
    .cancel     (cancel),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op and follow it to completion. Inputs change and outputs are
  // sampled on the falling edge. cycles = falling edges seen with busy high.
  task automatic issue_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int cancel_at, input bit intrude,
                          output int cycles, output int done_cnt, output logic done_end);
    @(negedge clk);
    funct = f; rs_content = a; rt_content = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; rs_content = $urandom; rt_content = $urandom;
    cycles = 0; done_cnt = 0;
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      if (done === 1'b1) done_cnt++;
      if (cycles == cancel_at) cancel = 1'b1;
      if (intrude && cycles == 5) begin
        start = 1'b1; funct = FUNCT_MULT; rs_content = 32'h10; rt_content = 32'h10;
      end
      @(negedge clk);
      cancel = 1'b0; start = 1'b0;
    end
    done_end = done;
    if (done === 1'b1) done_cnt++;
    @(negedge clk);
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; cancel = 1'b0; funct = '0; rs_content = '0; rt_content = '0;
    #12;
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 00000000", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 00000000", lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    @(negedge clk);
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
  endtask

  // Arithmetic vectors with fixed latency and a single done pulse.
  task automatic test_arith();
    logic [5:0]  vf[10]  = '{FUNCT_MULT, FUNCT_MULTU, FUNCT_MULT, FUNCT_MULT, FUNCT_DIV,
                             FUNCT_DIVU, FUNCT_DIV, FUNCT_DIVU, FUNCT_DIV, FUNCT_DIV};
    logic [31:0] va[10]  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFF9,
                             32'h00000007, 32'h00000007, 32'h00000064, 32'h80000000, 32'hFFFFFFF9};
    logic [31:0] vb[10]  = '{32'h00000005, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h00000002,
                             32'h00000002, 32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF, 32'h00000000};
    logic [31:0] vhi[10] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'h40000000, 32'h00000000, 32'hFFFFFFFF,
                             32'h00000001, 32'h00000001, 32'h00000064, 32'h00000000, 32'hFFFFFFF9};
    logic [31:0] vlo[10] = '{32'hFFFFFFF1, 32'h00000001, 32'h00000000, 32'h00000001, 32'hFFFFFFFD,
                             32'h00000003, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    int cycles; int dcnt; logic dend;
    for (int i = 0; i < 10; i++) begin
      issue_op(vf[i], va[i], vb[i], 0, 1'b0, cycles, dcnt, dend);
      checks++; if (cycles != 33) begin errors++; $display("FAIL arith%0d_latency: got %0d want 33", i, cycles); end
      checks++; if (dend !== 1'b1) begin errors++; $display("FAIL arith%0d_done: got %b want 1", i, dend); end
      checks++; if (dcnt != 1) begin errors++; $display("FAIL arith%0d_done_pulses: got %0d want 1", i, dcnt); end
      checks++; if (hi !== vhi[i]) begin errors++; $display("FAIL arith%0d_hi: got %h want %h", i, hi, vhi[i]); end
      checks++; if (lo !== vlo[i]) begin errors++; $display("FAIL arith%0d_lo: got %h want %h", i, lo, vlo[i]); end
      exp_hi = vhi[i]; exp_lo = vlo[i];
    end
  endtask

  // MTHI/MTLO, undefined funct, and cancel blocking a same-cycle start.
  task automatic test_move();
    @(negedge clk);
    funct = FUNCT_MTHI; rs_content = 32'hDEADBEEF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (hi !== 32'hDEADBEEF) begin errors++; $display("FAIL mthi_hi: got %h want deadbeef", hi); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mthi_done: got %b want 0", done); end
    funct = FUNCT_MTLO; rs_content = 32'h12345678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (lo !== 32'h12345678) begin errors++; $display("FAIL mtlo_lo: got %h want 12345678", lo); end
    checks++; if (hi !== 32'hDEADBEEF) begin errors++; $display("FAIL mtlo_hi_kept: got %h want deadbeef", hi); end
    exp_hi = 32'hDEADBEEF; exp_lo = 32'h12345678;
    funct = 6'h20; rs_content = 32'h0BADF00D; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL undef_busy: got %b want 0", busy); end
    checks++; if ({hi, lo} !== {exp_hi, exp_lo}) begin errors++; $display("FAIL undef_hilo: got %h/%h want %h/%h", hi, lo, exp_hi, exp_lo); end
    funct = FUNCT_MULT; rs_content = 32'h3; rt_content = 32'h3; start = 1'b1; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_start_busy: got %b want 0", busy); end
    funct = FUNCT_MTHI; rs_content = 32'h55555555; start = 1'b1; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    checks++; if (hi !== exp_hi) begin errors++; $display("FAIL cancel_mthi_hi: got %h want %h", hi, exp_hi); end
  endtask

  // A second start during an in-flight MULT is dropped.
  task automatic test_back_to_back();
    int cycles; int dcnt; logic dend;
    issue_op(FUNCT_MULT, 32'h6, 32'h7, 0, 1'b1, cycles, dcnt, dend);
    checks++; if (cycles != 33) begin errors++; $display("FAIL b2b_latency: got %0d want 33", cycles); end
    checks++; if (dcnt != 1) begin errors++; $display("FAIL b2b_done_pulses: got %0d want 1", dcnt); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL b2b_hi: got %h want 00000000", hi); end
    checks++; if (lo !== 32'h2A) begin errors++; $display("FAIL b2b_lo: got %h want 0000002a", lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_after: got %b want 0", busy); end
    exp_hi = 32'h0; exp_lo = 32'h2A;
  endtask

  // cancel in CALC and in FIX leaves HI/LO untouched, no done.
  task automatic test_cancel();
    int cycles; int dcnt; logic dend;
    int at[2] = '{10, 33};
    for (int i = 0; i < 2; i++) begin
      issue_op(FUNCT_DIV, 32'h00000064, 32'h00000007, at[i], 1'b0, cycles, dcnt, dend);
      checks++; if (cycles != at[i]) begin errors++; $display("FAIL cancel%0d_busy_cycles: got %0d want %0d", i, cycles, at[i]); end
      checks++; if (dcnt != 0) begin errors++; $display("FAIL cancel%0d_done_pulses: got %0d want 0", i, dcnt); end
      checks++; if ({hi, lo} !== {exp_hi, exp_lo}) begin errors++; $display("FAIL cancel%0d_hilo: got %h/%h want %h/%h", i, hi, lo, exp_hi, exp_lo); end
    end
  endtask

  // Asynchronous reset in the middle of a MULT.
  task automatic test_reset_mid_op();
    @(negedge clk);
    funct = FUNCT_MULT; rs_content = 32'h1234; rt_content = 32'h5678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_before: got %b want 1", busy); end
    #2 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL rst_mid_hi: got %h want 00000000", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL rst_mid_lo: got %h want 00000000", lo); end
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL rst_mid_no_result: got %h/%h want 0/0", hi, lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_idle: got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_move();
    test_back_to_back();
    test_cancel();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
